native2axis_bridge: RTL and testbench

NATIVE2AXIS_BRIDGE -- requirements
Module: native2axis_bridge

---
 rtl/native2axis_bridge.sv | 136 +++++++++++++
 tb/tb_native2axis_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native2axis_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | native2axis_bridge: native FIFO read port to AXI4-Stream master via 2-entry skid buf  |
// | Option macro N2S_TLAST_EN adds m_axis_tlast every PKT_LEN beats.  Revision: 1.0       |
// +--------------------------------------------------------------------------------------+
module native2axis_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata
`ifdef N2S_TLAST_EN
    ,
    output logic                  m_axis_tlast
`endif
);

`ifdef N2S_TLAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic               r_run;
    logic [1:0]         r_cnt;
    logic [ENTRY_W-1:0] r_buf0;
    logic [ENTRY_W-1:0] r_buf1;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_pop;
    logic               w_cap;
    logic               w_inflight;
    logic [1:0]         w_committed;

    // Holds rd_en low until the first rising edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign m_axis_tvalid = (r_cnt != 2'd0);
    assign m_axis_tdata  = r_buf0[DATA_WIDTH-1:0];
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign w_committed   = r_cnt - {1'b0, w_pop} + {1'b0, w_inflight};
    assign rd_en         = r_run && !empty && (w_committed < 2'd2);

    generate
        if (RD_LATENCY == 0) begin : g_fwft
            assign w_inflight = 1'b0;
            assign w_cap      = rd_en;
        end else begin : g_std
            logic r_rd_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_q <= 1'b0;
                end else begin
                    r_rd_q <= rd_en;
                end
            end
            assign w_inflight = r_rd_q;
            assign w_cap      = r_rd_q;
        end
    endgenerate

`ifdef N2S_TLAST_EN
    logic [15:0] r_tag_cnt;
    logic [15:0] r_beat_cnt;
    logic        w_tag;

    // Tag each word at capture time so tlast travels with its data through the buffer.
    assign w_tag        = (r_tag_cnt == 16'(PKT_LEN - 1));
    assign w_entry      = {w_tag, dout};
    assign m_axis_tlast = m_axis_tvalid && r_buf0[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_cap) begin
                r_tag_cnt <= w_tag ? 16'd0 : r_tag_cnt + 16'd1;
            end
            if (w_pop) begin
                r_beat_cnt <= (r_beat_cnt == 16'(PKT_LEN - 1)) ? 16'd0 : r_beat_cnt + 16'd1;
            end
        end
    end
`else
    assign w_entry = dout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_pop, w_cap})
                2'b10: begin
                    r_buf0 <= r_buf1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd0) begin
                        r_buf0 <= w_entry;
                    end else begin
                        r_buf1 <= w_entry;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands directly behind the departing head.
                    if (r_cnt == 2'd1) begin
                        r_buf0 <= w_entry;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_native2axis_bridge.sv
`default_nettype none
// Directed and randomised checks of native2axis_bridge in standard (A) and FWFT (B) modes.
module tb_native2axis_bridge;

    logic        clk;
    logic        rst_n;

    logic        a_empty, a_rd_en, a_tready, a_tvalid, a_gate;
    logic [31:0] a_dout, a_tdata;
    logic        b_empty, b_rd_en, b_tready, b_tvalid, b_gate;
    logic [31:0] b_dout, b_tdata;
`ifdef N2S_TLAST_EN
    logic        a_tlast, b_tlast;
`endif

    logic [31:0] a_mem [0:16383];
    logic [31:0] b_mem [0:1023];
    int          a_rp = 0;
    int          a_wp;
    int          b_rp = 0;
    int          b_wp;

    int          vectors;
    int          miscompares;

    native2axis_bridge #(.DATA_WIDTH(32), .RD_LATENCY(1), .PKT_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .empty(a_empty), .rd_en(a_rd_en), .dout(a_dout),
        .m_axis_tready(a_tready), .m_axis_tvalid(a_tvalid), .m_axis_tdata(a_tdata)
`ifdef N2S_TLAST_EN
        , .m_axis_tlast(a_tlast)
`endif
    );

    native2axis_bridge #(.DATA_WIDTH(32), .RD_LATENCY(0), .PKT_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .empty(b_empty), .rd_en(b_rd_en), .dout(b_dout),
        .m_axis_tready(b_tready), .m_axis_tvalid(b_tvalid), .m_axis_tdata(b_tdata)
`ifdef N2S_TLAST_EN
        , .m_axis_tlast(b_tlast)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: A registers dout one cycle after rd_en, B shows the head word combinationally.
    assign a_empty = (a_rp == a_wp) || a_gate;
    always @(posedge clk) begin
        if (a_rd_en) begin
            a_dout <= a_mem[a_rp[13:0]];
            a_rp   <= a_rp + 1;
        end
    end

    assign b_empty = (b_rp == b_wp) || b_gate;
    assign b_dout  = b_mem[b_rp[9:0]];
    always @(posedge clk) begin
        if (b_rd_en) begin
            b_rp <= b_rp + 1;
        end
    end

    task automatic push_a(input logic [31:0] val);
        a_mem[a_wp[13:0]] = val;
        a_wp++;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 8; i++) push_a(32'(i));
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (a_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %0b want 0", a_tvalid); end
        vectors++;
        if (a_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", a_tdata); end
        vectors++;
        if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %0b want 0", a_rd_en); end
        vectors++;
        if (b_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_b_tvalid: got %0b want 0", b_tvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL release_rd_en: got %0b want 0 before first edge", a_rd_en); end
    endtask

    task automatic test_stream();
        int first_rd = -1;
        int last_rd  = -1;
        int rd_cnt   = 0;
        int first_v  = -1;
        int last_v   = -1;
        int beats    = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            #1;
            if (a_rd_en) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                rd_cnt++;
            end
            if (a_tvalid && a_tready) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                vectors++;
                if (a_tdata !== 32'(beats + 1)) begin
                    miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", beats, a_tdata, beats + 1);
                end
                beats++;
            end
        end
        vectors++;
        if (rd_cnt != 8 || last_rd - first_rd != 7) begin
            miscompares++; $display("FAIL stream_rd_en: got %0d reads span %0d want 8 span 7", rd_cnt, last_rd - first_rd);
        end
        vectors++;
        if (first_v - first_rd != 2) begin
            miscompares++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd);
        end
        vectors++;
        if (beats != 8 || last_v - first_v != 7) begin
            miscompares++; $display("FAIL stream_beats: got %0d beats span %0d want 8 span 7", beats, last_v - first_v);
        end
    endtask

    task automatic test_backpressure();
        int          rp_start;
        int          beats   = 0;
        int          first_v = -1;
        logic [31:0] exp_d;
        @(negedge clk);
        a_tready = 1'b0;
        rp_start = a_rp;
        push_a(32'hA);
        push_a(32'hB);
        push_a(32'hC);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (a_tvalid) begin
                vectors++;
                if (a_tdata !== 32'hA) begin miscompares++; $display("FAIL bp_hold: got %h want a", a_tdata); end
            end
        end
        vectors++;
        if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL bp_rd_en: got %0b want 0", a_rd_en); end
        vectors++;
        if (a_tvalid !== 1'b1) begin miscompares++; $display("FAIL bp_tvalid: got %0b want 1", a_tvalid); end
        vectors++;
        if (a_rp - rp_start != 2) begin miscompares++; $display("FAIL bp_reads: got %0d want 2", a_rp - rp_start); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) a_tready = 1'b1;
            #1;
            if (a_tvalid && a_tready) begin
                if (first_v < 0) first_v = c;
                exp_d = 32'hA + 32'(beats);
                vectors++;
                if (a_tdata !== exp_d || c != first_v + beats) begin
                    miscompares++; $display("FAIL bp_release[%0d]: got %h at cycle %0d want %h at %0d", beats, a_tdata, c, exp_d, first_v + beats);
                end
                beats++;
            end
        end
        vectors++;
        if (beats != 3 || first_v != 0) begin miscompares++; $display("FAIL bp_count: got %0d first %0d want 3 first 0", beats, first_v); end
    endtask

    task automatic test_lat0();
        int first_rd = -1;
        int first_v  = -1;
        int last_v   = -1;
        int beats    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 4; i++) begin
                    b_mem[b_wp[9:0]] = 32'h11 + 32'(i);
                    b_wp++;
                end
            end
            #1;
            if (b_rd_en && first_rd < 0) first_rd = c;
            if (b_tvalid && b_tready) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                vectors++;
                if (b_tdata !== 32'h11 + 32'(beats)) begin
                    miscompares++; $display("FAIL lat0_data[%0d]: got %h want %h", beats, b_tdata, 32'h11 + 32'(beats));
                end
                beats++;
            end
        end
        vectors++;
        if (first_v - first_rd != 1) begin miscompares++; $display("FAIL lat0_latency: got %0d want 1", first_v - first_rd); end
        vectors++;
        if (beats != 4 || last_v - first_v != 3) begin miscompares++; $display("FAIL lat0_beats: got %0d span %0d want 4 span 3", beats, last_v - first_v); end
    endtask

    task automatic test_reset_midstream();
        int beats   = 0;
        int first_v = -1;
        @(negedge clk);
        a_tready = 1'b0;
        for (int i = 0; i < 5; i++) push_a(32'h21 + 32'(i));
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (a_tvalid !== 1'b1 || a_tdata !== 32'h21) begin
            miscompares++; $display("FAIL mid_pre: got v=%0b d=%h want v=1 d=21", a_tvalid, a_tdata);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_tvalid !== 1'b0 || a_tdata !== 32'h0 || a_rd_en !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset: got v=%0b d=%h rd=%0b want 0 0 0", a_tvalid, a_tdata, a_rd_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        a_tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (a_tvalid && a_tready) begin
                if (first_v < 0) first_v = c;
                vectors++;
                if (a_tdata !== 32'h23 + 32'(beats) || c != first_v + beats) begin
                    miscompares++; $display("FAIL mid_post[%0d]: got %h want %h", beats, a_tdata, 32'h23 + 32'(beats));
                end
                beats++;
            end
        end
        vectors++;
        if (beats != 3) begin miscompares++; $display("FAIL mid_count: got %0d want 3", beats); end
    endtask

`ifdef N2S_TLAST_EN
    task automatic test_tlast();
        int   beats = 0;
        logic exp_l;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) push_a(32'h31 + 32'(i));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (a_tvalid && a_tready) begin
                exp_l = ((beats % 4) == 3);
                vectors++;
                if (a_tlast !== exp_l || a_tdata !== 32'h31 + 32'(beats)) begin
                    miscompares++; $display("FAIL tlast[%0d]: got l=%0b d=%h want l=%0b d=%h", beats, a_tlast, a_tdata, exp_l, 32'h31 + 32'(beats));
                end
                beats++;
            end
        end
        vectors++;
        if (beats != 10 || dut_a.r_beat_cnt !== 16'd2) begin
            miscompares++; $display("FAIL tlast_counter: got beats=%0d cnt=%0d want 10 2", beats, dut_a.r_beat_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int          exp_idx   = a_rp;
        int          got       = 0;
        logic        prev_hold = 1'b0;
        logic [31:0] prev_d    = '0;
        for (int i = 0; i < 10000; i++) push_a($urandom);
        for (int c = 0; c < 60000 && got < 10000; c++) begin
            @(negedge clk);
            a_tready = ($urandom_range(0, 3) != 0);
            a_gate   = ($urandom_range(0, 3) == 0);
            #1;
            if (a_empty) begin
                vectors++;
                if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL rnd_rd_empty: got rd_en=1 want 0 at cycle %0d", c); end
            end
            if (prev_hold) begin
                vectors++;
                if (a_tvalid !== 1'b1 || a_tdata !== prev_d) begin
                    miscompares++; $display("FAIL rnd_stable: got v=%0b d=%h want v=1 d=%h", a_tvalid, a_tdata, prev_d);
                end
            end
            if (a_tvalid && a_tready) begin
                vectors++;
                if (a_tdata !== a_mem[exp_idx[13:0]]) begin
                    miscompares++; $display("FAIL rnd_order[%0d]: got %h want %h", got, a_tdata, a_mem[exp_idx[13:0]]);
                end
                exp_idx++;
                got++;
            end
            prev_hold = a_tvalid && !a_tready;
            prev_d    = a_tdata;
        end
        a_gate = 1'b0;
        vectors++;
        if (got != 10000) begin miscompares++; $display("FAIL rnd_timeout: got %0d beats want 10000", got); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        a_tready    = 1'b1;
        b_tready    = 1'b1;
        a_gate      = 1'b0;
        b_gate      = 1'b0;
        a_wp        = 0;
        b_wp        = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_lat0();
        test_reset_midstream();
`ifdef N2S_TLAST_EN
        test_tlast();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
